// File: rtl/rx_seq_checker.sv
// rx_seq_checker
//   Pops 16-bit words from the receive FIFO and checks them against the host
//   test pattern {n, n+1}, where n advances by 2 per word (mod 256). Keeps a
//   wrapping word counter, a saturating error counter, a sticky error flag,
//   a lock indication and an activity LED for board bring-up.
//
// Ports
//   clk_i       system clock (FIFO read-side clock)
//   rst_i       asynchronous active-high reset
//   enable_i    permits new FIFO pops
//   clear_i     synchronous clear of counters, sticky flag and lock state
//   rx_en_o     FIFO pop strobe
//   rx_out_i    FIFO read data, valid the cycle after a pop
//   rx_empty_i  FIFO empty flag
//   word_cnt_o  words checked (wraps)
//   err_cnt_o   mismatching words (saturates)
//   locked_o    synchronised to the pattern
//   err_flag_o  sticky error flag
//   act_led_o   toggles every 2^ACT_SHIFT checked words
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SYNC   | hunting: next well-formed word establishes the expected value
// ST_LOCKED | tracking: each word is compared against the expected value
module rx_seq_checker #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned ERR_WIDTH = 16,
  parameter int unsigned ACT_SHIFT = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  output logic                 rx_en_o,
  input  logic [15:0]          rx_out_i,
  input  logic                 rx_empty_i,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  output logic [ERR_WIDTH-1:0] err_cnt_o,
  output logic                 locked_o,
  output logic                 err_flag_o,
  output logic                 act_led_o
);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] ACT_MASK =
    CNT_WIDTH'((64'd1 << ACT_SHIFT) - 64'd1);

  state_e                 state_q, state_d;
  logic                   rd_valid_q;
  logic [7:0]             exp_q, exp_d;
  logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d, word_inc;
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                   err_flag_q, err_flag_d;
  logic                   act_led_q, act_led_d;

  logic [7:0]             byte_a, byte_b;
  logic                   well_formed;
  logic                   check;
  logic                   err_hit;

  // Pop is combinational so the FIFO sees it in the same cycle; reset masks it
  // so nothing is pulled from the FIFO while the checker cannot accept it.
  assign rx_en_o = enable_i & ~rx_empty_i & ~rst_i;

  assign byte_a      = rx_out_i[15:8];
  assign byte_b      = rx_out_i[7:0];
  assign well_formed = (byte_b == byte_a + 8'd1);
  // clear has priority: a word arriving during clear is discarded unseen.
  assign check       = rd_valid_q & ~clear_i;
  assign word_inc    = word_cnt_q + CNT_WIDTH'(1);

  // State register plus datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SYNC;
      rd_valid_q <= 1'b0;
      exp_q      <= 8'h00;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      act_led_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rx_en_o;
      exp_q      <= exp_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      act_led_q  <= act_led_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_SYNC;
    end else if (check) begin
      case (state_q)
        ST_SYNC:   if (well_formed)  state_d = ST_LOCKED;
        ST_LOCKED: if (!well_formed) state_d = ST_SYNC;
        default:   state_d = ST_SYNC;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    err_hit = 1'b0;
    if (check) begin
      case (state_q)
        ST_SYNC:   err_hit = ~well_formed;
        ST_LOCKED: err_hit = ~well_formed | (byte_a != exp_q);
        default:   err_hit = 1'b0;
      endcase
    end

    // Any well-formed word (first lock, in-sequence, or a gap) re-anchors the
    // expected value on the word just seen.
    exp_d = exp_q;
    if (clear_i) begin
      exp_d = 8'h00;
    end else if (check && well_formed) begin
      exp_d = byte_a + 8'd2;
    end

    word_cnt_d = word_cnt_q;
    act_led_d  = act_led_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clear_i) begin
      word_cnt_d = '0;
      act_led_d  = 1'b0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else begin
      if (check) begin
        word_cnt_d = word_inc;
        if ((word_inc & ACT_MASK) == '0) act_led_d = ~act_led_q;
      end
      if (err_hit) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
      end
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign locked_o   = (state_q == ST_LOCKED);
  assign err_flag_o = err_flag_q;
  assign act_led_o  = act_led_q;

endmodule

// File: tb/tb_rx_seq_checker.sv
module tb_rx_seq_checker;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [15:0] rx_out;
  logic        rx_empty;

  logic        rx_en_a, locked_a, err_flag_a, act_a;
  logic [31:0] word_cnt_a;
  logic [15:0] err_cnt_a;

  logic        rx_en_b, locked_b, err_flag_b, act_b;
  logic [7:0]  word_cnt_b;
  logic [1:0]  err_cnt_b;

  int compared   = 0;
  int mismatched = 0;

  rx_seq_checker dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .rx_en_o(rx_en_a), .rx_out_i(rx_out), .rx_empty_i(rx_empty),
    .word_cnt_o(word_cnt_a), .err_cnt_o(err_cnt_a), .locked_o(locked_a),
    .err_flag_o(err_flag_a), .act_led_o(act_a)
  );

  rx_seq_checker #(.CNT_WIDTH(8), .ERR_WIDTH(2), .ACT_SHIFT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .rx_en_o(rx_en_b), .rx_out_i(rx_out), .rx_empty_i(rx_empty),
    .word_cnt_o(word_cnt_b), .err_cnt_o(err_cnt_b), .locked_o(locked_b),
    .err_flag_o(err_flag_b), .act_led_o(act_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents and the reference model of the checker.
  logic [15:0] fifo[$];
  bit          inflight = 0;
  logic [15:0] inflight_word;
  int          pops = 0;
  longint      m_cnt = 0;
  longint      m_errs = 0;
  bit          m_locked = 0;
  bit          m_flag = 0;
  int          m_exp = 0;

  task automatic chk(input string name, input longint got, input longint want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void model_clear();
    m_cnt = 0; m_errs = 0; m_flag = 0; m_locked = 0; m_exp = 0;
  endfunction

  function automatic void model_err();
    m_errs++;
    m_flag = 1;
  endfunction

  function automatic void model_check(input logic [15:0] w);
    int a, b;
    bit wf;
    a  = int'(w[15:8]);
    b  = int'(w[7:0]);
    wf = (b == (a + 1) % 256);
    m_cnt++;
    if (!m_locked) begin
      if (wf) begin
        m_locked = 1;
        m_exp = (a + 2) % 256;
      end else model_err();
    end else if (wf && a == m_exp) begin
      m_exp = (m_exp + 2) % 256;
    end else if (wf) begin
      model_err();
      m_exp = (a + 2) % 256;
    end else begin
      model_err();
      m_locked = 0;
    end
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Per-cycle FIFO service, model update and comparison, 1 time unit after
  // each rising edge (inputs were last changed on the falling edge).
  initial begin
    bit exp_pop;
    forever begin
      @(posedge clk);
      #1;
      exp_pop = !rst && enable && (fifo.size() > 0);
      chk("rx_en_a", rx_en_a, exp_pop);
      chk("rx_en_b", rx_en_b, exp_pop);
      if (rst) begin
        model_clear();
        inflight = 0;
      end else begin
        if (inflight && !clear) model_check(inflight_word);
        if (clear) model_clear();
        inflight = exp_pop;
        if (exp_pop) begin
          rx_out = fifo.pop_front();
          inflight_word = rx_out;
          pops++;
        end
        rx_empty = (fifo.size() == 0);
      end
      chk("word_cnt_a", word_cnt_a, m_cnt & 64'hFFFF_FFFF);
      chk("word_cnt_b", word_cnt_b, m_cnt & 64'hFF);
      chk("err_cnt_a",  err_cnt_a,  sat(m_errs, 65535));
      chk("err_cnt_b",  err_cnt_b,  sat(m_errs, 3));
      chk("locked_a",   locked_a,   m_locked);
      chk("locked_b",   locked_b,   m_locked);
      chk("err_flag_a", err_flag_a, m_flag);
      chk("err_flag_b", err_flag_b, m_flag);
      chk("act_led_a",  act_a,      (m_cnt >> 12) & 1);
      chk("act_led_b",  act_b,      (m_cnt >> 2) & 1);
    end
  end

  task automatic push(input logic [15:0] w);
    fifo.push_back(w);
    rx_empty = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    enable = 1'b1;
    clear  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fifo.size() == 0 && !inflight) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int          base_pops;
    longint      base_cnt;
    logic [7:0]  g, a8, b8;
    logic [15:0] w;
    int          r, pushed;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; rx_out = 16'h0; rx_empty = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_word_cnt", word_cnt_a, 0);
    chk("reset_err_cnt",  err_cnt_a, 0);
    chk("reset_locked",   locked_a, 0);
    chk("reset_act",      act_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic in-sequence stream.
    base_pops = pops;
    push(16'h0001); push(16'h0203); push(16'h0405);
    drain();
    chk("t1_pops",     pops - base_pops, 3);
    chk("t1_word_cnt", word_cnt_a, 3);
    chk("t1_err_cnt",  err_cnt_a, 0);
    chk("t1_locked",   locked_a, 1);
    chk("t1_err_flag", err_flag_a, 0);
    chk("t1_model_cnt", m_cnt, 3);

    // Pattern wrap across 0xFF -> 0x00.
    pulse_clear();
    push(16'hFCFD); push(16'hFEFF); push(16'h0001);
    drain();
    chk("t2_word_cnt", word_cnt_a, 3);
    chk("t2_err_cnt",  err_cnt_a, 0);
    chk("t2_locked",   locked_a, 1);

    // Dropped words: one error, stays locked.
    pulse_clear();
    push(16'h0001); push(16'h0203); push(16'h0809); push(16'h0A0B);
    drain();
    chk("t3_word_cnt", word_cnt_a, 4);
    chk("t3_err_cnt",  err_cnt_a, 1);
    chk("t3_err_flag", err_flag_a, 1);
    chk("t3_locked",   locked_a, 1);
    chk("t3_model_errs", m_errs, 1);

    // Corruption: lose lock, relock.
    pulse_clear();
    push(16'h0001); push(16'h1234); push(16'h5657); push(16'h5859);
    drain();
    chk("t4_err_cnt",   err_cnt_a, 1);
    chk("t4_err_cnt_b", err_cnt_b, 1);
    chk("t4_locked",    locked_a, 1);
    chk("t4_word_cnt",  word_cnt_a, 4);
    chk("t4_model_locked", m_locked, 1);

    // Empty FIFO: no pops, no counting.
    base_cnt = word_cnt_a;
    base_pops = pops;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_empty_rx_en", rx_en_a, 0);
    end
    chk("t5_empty_cnt",  word_cnt_a, base_cnt);
    chk("t5_empty_pops", pops - base_pops, 0);

    // Enable dropped right after a pop.
    push(16'h5A5B); push(16'h5C5D);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_drop_pops", pops - base_pops, 1);
    chk("t5_drop_cnt",  word_cnt_a, base_cnt + 1);
    chk("t5_drop_left", fifo.size(), 1);
    drain();
    chk("t5_drop_err", err_cnt_a, 1);

    // Saturation on the 2-bit error counter, then clear during rd_valid.
    pulse_clear();
    for (int i = 0; i < 5; i++) push(16'h1111);
    drain();
    chk("t6_err_cnt_b", err_cnt_b, 3);
    chk("t6_err_cnt_a", err_cnt_a, 5);
    chk("t6_err_flag_b", err_flag_b, 1);
    push(16'h0001);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t6_clr_word_cnt_a", word_cnt_a, 0);
    chk("t6_clr_word_cnt_b", word_cnt_b, 0);
    chk("t6_clr_err_cnt_b",  err_cnt_b, 0);
    chk("t6_clr_err_flag",   err_flag_a, 0);
    chk("t6_clr_locked",     locked_a, 0);
    chk("t6_model_cnt",      m_cnt, 0);

    // Reset in mid-stream: the in-flight 0x0203 is lost, resync on 0x0405.
    push(16'h0001); push(16'h0203); push(16'h0405);
    push(16'h0607); push(16'h0809); push(16'h0A0B);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_rx_en",    rx_en_a, 0);
    chk("t7_rst_word_cnt", word_cnt_a, 0);
    @(negedge clk);
    rst = 1'b0;
    drain();
    chk("t7_word_cnt", word_cnt_a, 4);
    chk("t7_err_cnt",  err_cnt_a, 0);
    chk("t7_locked",   locked_a, 1);

    // Randomized traffic: mostly in-sequence, with gaps, corruption,
    // stalls and occasional clears.
    g = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 99) < 80);
      clear  = ($urandom_range(0, 299) == 0);
      if (fifo.size() < 6 && $urandom_range(0, 99) < 60) begin
        r = $urandom_range(0, 99);
        if (r < 85) begin
          w = {g, g + 8'd1}; g = g + 8'd2;
        end else if (r < 92) begin
          g = g + 8'(2 * $urandom_range(1, 5));
          w = {g, g + 8'd1}; g = g + 8'd2;
        end else begin
          a8 = 8'($urandom);
          b8 = a8 + 8'd1 + 8'($urandom_range(1, 254));
          w = {a8, b8};
        end
        push(w);
      end
    end
    drain();

    // Long clean stream to carry the default activity LED past 4096 words.
    pulse_clear();
    g = 8'h00;
    pushed = 0;
    enable = 1'b1;
    while (pushed < 4200) begin
      @(negedge clk);
      if (fifo.size() < 4) begin
        push({g, g + 8'd1});
        g = g + 8'd2;
        pushed++;
      end
    end
    drain();
    chk("t9_word_cnt", word_cnt_a, 4200);
    chk("t9_act_led",  act_a, 1);
    chk("t9_err_cnt",  err_cnt_a, 0);
    chk("t9_word_cnt_b_wrap", word_cnt_b, 4200 % 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rx_seq_checker.md
Name: rx_seq_checker

Overview:
- Sits directly downstream of the ft600_mode245 receive FIFO.
- Pops 16-bit words from the FIFO and checks them against the host test pattern: byte pairs {n, n+1}, with n advancing by 2 per word, modulo 256.
- Keeps word and error counters, tracks a lock state, and drives status LEDs for link bring-up on the board.

Parameters:
- CNT_WIDTH, 32, width of the received-word counter.
- ERR_WIDTH, 16, width of the saturating error counter.
- ACT_SHIFT, 12, activity LED toggles every 2^ACT_SHIFT checked words.

Ports:
- clk  input  1  system clock; same clock as the FIFO read side.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  permits new FIFO pops.
- clear  input  1  synchronous clear of counters, sticky flag and lock state.
- rx_en  output  1  FIFO pop strobe (connects to the FIFO rx_en).
- rx_out  input  16  FIFO read data, valid one cycle after a pop.
- rx_empty  input  1  FIFO empty flag.
- word_cnt  output  CNT_WIDTH  number of words checked.
- err_cnt  output  ERR_WIDTH  number of mismatching words; saturates.
- locked  output  1  checker is synchronised to the pattern.
- err_flag  output  1  sticky; set on any error.
- act_led  output  1  activity indicator.

Behaviour:
- Reset (async, rst=1): rx_en=0, word_cnt=0, err_cnt=0, locked=0, err_flag=0, act_led=0, state=SYNC, rd_valid=0, exp=0.
- Pop rule:
  - rx_en = enable & ~rx_empty & ~rst. Combinational, at most one pop per cycle.
  - rd_valid is registered rx_en. When rd_valid=1, rx_out is sampled that cycle: one-cycle read latency.
- Enable low: no new pops. A word popped in the previous cycle is still checked.
- Word decode: a = rx_out[15:8], b = rx_out[7:0]. The word is well-formed when b == a+1 mod 256 (0xFF followed by 0x00 is well-formed).
- Every checked word (rd_valid=1, clear=0): word_cnt increments, wrapping at 2^CNT_WIDTH.
- Activity LED: act_led toggles when the low ACT_SHIFT bits of the incremented word_cnt are all zero.
- State SYNC (locked=0):
  - Well-formed word: go to LOCKED, exp <= a+2 mod 256. No error counted.
  - Malformed word: stay in SYNC, record an error.
- State LOCKED (locked=1):
  - Word equals {exp, exp+1}: good, exp <= exp+2 mod 256.
  - Well-formed word with a != exp: record an error, stay LOCKED, relock with exp <= a+2. This is a gap or drop.
  - Malformed word: record an error, go to SYNC.
- Error recording: err_cnt increments and saturates at all-ones; err_flag <= 1.
- Output timing: locked, word_cnt, err_cnt and err_flag all update on the clock edge at the end of the rd_valid cycle, i.e. two cycles after the pop.
- clear=1:
  - Counters and err_flag go to 0, act_led to 0, state to SYNC.
  - A word arriving with rd_valid in the same cycle is discarded: not counted, not checked. clear has priority.
  - Popping continues during clear.
- Reset mid-stream: any in-flight read is dropped. After release, the checker starts in SYNC on the next popped word.
- Error cases: err_cnt at max stays at max while err_flag stays 1. word_cnt wrap does not affect error state.

Test Plan:
- Reset, then FIFO holds 0x0001, 0x0203, 0x0405 with enable=1 -> three single-cycle rx_en pulses; locked=1 after the first word; word_cnt=3, err_cnt=0, err_flag=0.
- Wrap: stream 0xFCFD, 0xFEFF, 0x0001 -> err_cnt=0, word_cnt=3, locked stays 1 across the 0xFF→0x00 boundary.
- Drop: stream 0x0001, 0x0203, 0x0809, 0x0A0B -> err_cnt=1, err_flag=1, locked stays 1, word_cnt=4.
- Corruption: stream 0x0001, 0x1234, 0x5657, 0x5859 -> err_cnt=1; locked=0 after 0x1234; relocks on 0x5657; final locked=1.
- Flow control:
  - rx_empty=1 -> rx_en=0 and no counter change.
  - enable dropped in the cycle after a pop -> that word is still counted and no further rx_en occurs.
- Clear and saturation:
  - ERR_WIDTH=2, feed 5 malformed words -> err_cnt=3.
  - Then pulse clear coincident with rd_valid -> all counters 0, err_flag=0, locked=0, and the coincident word is not counted.
